// File: rtl/bus_arb_if.sv
// Shared snoopy-bus signal bundle between the requesters/agents and the slot arbiter.
// Requester-side fields are packed per requester: cmd at [3i+:3], tag at [5i+:5], addr at [26i+:26], data at [64i+:64].
interface bus_arb_if #(
  parameter int NREQ  = 4,
  parameter int CYC_W = 3
);
  logic [NREQ-1:0]      req_valid;
  logic [3*NREQ-1:0]    req_cmd;
  logic [5*NREQ-1:0]    req_tag;
  logic [26*NREQ-1:0]   req_addr;
  logic [64*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      bus_hit_in;
  logic [NREQ-1:0]      bus_nack_in;

  logic [NREQ-1:0]      grant;
  logic [CYC_W-1:0]     bus_cycle;
  logic                 bus_valid;
  logic [2:0]           bus_cmd;
  logic [4:0]           bus_tag;
  logic [25:0]          bus_addr;
  logic [63:0]          bus_data;
  logic [NREQ-1:0]      resp_valid;
  logic                 resp_hit;
  logic                 resp_nack;

  // Requesters and snooping agents
  modport master (
    output req_valid, req_cmd, req_tag, req_addr, req_data, bus_hit_in, bus_nack_in,
    input  grant, bus_cycle, bus_valid, bus_cmd, bus_tag, bus_addr, bus_data,
    input  resp_valid, resp_hit, resp_nack
  );

  // Arbiter
  modport slave (
    input  req_valid, req_cmd, req_tag, req_addr, req_data, bus_hit_in, bus_nack_in,
    output grant, bus_cycle, bus_valid, bus_cmd, bus_tag, bus_addr, bus_data,
    output resp_valid, resp_hit, resp_nack
  );
endinterface

// File: rtl/bus_arb.sv
// Slot-based round-robin arbiter for the shared snoopy bus: owns the slot counter,
// grants one requester per slot, muxes its fields onto the bus and returns hit/nack.
module bus_arb #(
  parameter int NREQ        = 4,
  parameter int SLOT_CYCLES = 8,
  parameter int CYC_W       = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  bus_arb_if.slave    bus_io
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(SLOT_CYCLES - 1);

  logic [CYC_W-1:0] cycle_q;
  logic [NREQ-1:0]  grant_q;
  logic [NREQ-1:0]  grant_d;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [NREQ-1:0]  resp_valid_q;
  logic             resp_hit_q;
  logic             resp_nack_q;

  logic [NREQ-1:0]  cand;
  logic [PTR_W-1:0] idx;
  logic             found;
  logic             last_cyc;

  assign last_cyc = (cycle_q == LAST_CYC);

  // The current grantee is not a candidate: its result is only known after this slot.
  always_comb begin
    cand    = bus_io.req_valid & ~grant_q;
    grant_d = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PTR_W'((int'(ptr_q) + k) % NREQ);
      if (!found && cand[idx]) begin
        found        = 1'b1;
        grant_d[idx] = 1'b1;
        ptr_d        = (int'(idx) == NREQ - 1) ? '0 : idx + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q      <= '0;
      grant_q      <= '0;
      ptr_q        <= '0;
      resp_valid_q <= '0;
      resp_hit_q   <= 1'b0;
      resp_nack_q  <= 1'b0;
    end else begin
      cycle_q      <= cycle_q + CYC_W'(1);
      resp_valid_q <= '0;
      resp_hit_q   <= 1'b0;
      resp_nack_q  <= 1'b0;
      if (last_cyc) begin
        grant_q <= grant_d;
        ptr_q   <= ptr_d;
        if (|grant_q) begin
          resp_valid_q <= grant_q;
          resp_hit_q   <= |bus_io.bus_hit_in;
          resp_nack_q  <= |bus_io.bus_nack_in;
        end
      end
    end
  end

  // Grant is one-hot or zero, so an AND-OR mux yields the grantee's fields or 0 when idle.
  logic [2:0]  cmd_m  [NREQ];
  logic [4:0]  tag_m  [NREQ];
  logic [25:0] addr_m [NREQ];
  logic [63:0] data_m [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_mask
      assign cmd_m[gi]  = grant_q[gi] ? bus_io.req_cmd[3*gi +: 3]    : 3'd0;
      assign tag_m[gi]  = grant_q[gi] ? bus_io.req_tag[5*gi +: 5]    : 5'd0;
      assign addr_m[gi] = grant_q[gi] ? bus_io.req_addr[26*gi +: 26] : 26'd0;
      assign data_m[gi] = grant_q[gi] ? bus_io.req_data[64*gi +: 64] : 64'd0;
    end
  endgenerate

  logic [2:0]  cmd_or;
  logic [4:0]  tag_or;
  logic [25:0] addr_or;
  logic [63:0] data_or;

  always_comb begin
    cmd_or  = '0;
    tag_or  = '0;
    addr_or = '0;
    data_or = '0;
    for (int i = 0; i < NREQ; i++) begin
      cmd_or  = cmd_or  | cmd_m[i];
      tag_or  = tag_or  | tag_m[i];
      addr_or = addr_or | addr_m[i];
      data_or = data_or | data_m[i];
    end
  end

  assign bus_io.grant      = grant_q;
  assign bus_io.bus_cycle  = cycle_q;
  assign bus_io.bus_valid  = (|grant_q) && (cycle_q == '0);
  assign bus_io.bus_cmd    = cmd_or;
  assign bus_io.bus_tag    = tag_or;
  assign bus_io.bus_addr   = addr_or;
  assign bus_io.bus_data   = data_or;
  assign bus_io.resp_valid = resp_valid_q;
  assign bus_io.resp_hit   = resp_hit_q;
  assign bus_io.resp_nack  = resp_nack_q;

endmodule

// File: tb/tb_bus_arb.sv
// Bench for bus_arb: directed scenarios plus random traffic, checked every cycle
// against a slot-level model (integer grantee, pointer and pending response).
module tb_bus_arb;
  localparam int NREQ = 4;
  localparam int SC   = 8;
  localparam int CW   = 3;
  localparam logic [2:0] CMD_BUSRD = 3'b001;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_arb_if #(.NREQ(NREQ), .CYC_W(CW)) bif ();

  bus_arb #(.NREQ(NREQ), .SLOT_CYCLES(SC), .CYC_W(CW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bif.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: current position, grantee (-1 idle), pointer, requester responded to this cycle (-1 none)
  int m_cyc, m_gnt, m_ptr, m_resp;
  bit m_hit, m_nack;
  bit rand_mode = 1'b0;
  bit rr_mode   = 1'b0;
  bit data_mode = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic raise(input int i, input logic [2:0] c, input logic [4:0] t, input logic [25:0] a);
    bif.req_valid[i]          = 1'b1;
    bif.req_cmd[3*i +: 3]     = c;
    bif.req_tag[5*i +: 5]     = t;
    bif.req_addr[26*i +: 26]  = a;
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] eg, er;
    logic [2:0]  ecmd;
    logic [4:0]  etag;
    logic [25:0] eaddr;
    logic [63:0] edata;
    eg = '0; er = '0; ecmd = '0; etag = '0; eaddr = '0; edata = '0;
    if (m_gnt >= 0) begin
      eg    = NREQ'(1) << m_gnt;
      ecmd  = bif.req_cmd[3*m_gnt +: 3];
      etag  = bif.req_tag[5*m_gnt +: 5];
      eaddr = bif.req_addr[26*m_gnt +: 26];
      edata = bif.req_data[64*m_gnt +: 64];
    end
    if (m_resp >= 0) er = NREQ'(1) << m_resp;
    chk("grant",      64'(bif.grant),      64'(eg));
    chk("bus_cycle",  64'(bif.bus_cycle),  64'(m_cyc));
    chk("bus_valid",  64'(bif.bus_valid),  64'(m_gnt >= 0 && m_cyc == 0));
    chk("bus_cmd",    64'(bif.bus_cmd),    64'(ecmd));
    chk("bus_tag",    64'(bif.bus_tag),    64'(etag));
    chk("bus_addr",   64'(bif.bus_addr),   64'(eaddr));
    chk("bus_data",   bif.bus_data,        edata);
    chk("resp_valid", 64'(bif.resp_valid), 64'(er));
    if (m_resp >= 0) begin
      chk("resp_hit",  64'(bif.resp_hit),  64'(m_hit));
      chk("resp_nack", 64'(bif.resp_nack), 64'(m_nack));
      $display("t=%0t resp req=%0d hit=%0b nack=%0b", $time, m_resp, bif.resp_hit, bif.resp_nack);
    end
  endtask

  // Advance one clock: update the model from the inputs of the ending cycle, then compare.
  task automatic step();
    int w;
    w = -1;
    if (m_cyc == SC - 1) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (w < 0 && bif.req_valid[j] && j != m_gnt) w = j;
      end
      m_resp = m_gnt;
      m_hit  = |bif.bus_hit_in;
      m_nack = |bif.bus_nack_in;
      m_gnt  = w;
      if (w >= 0) m_ptr = (w + 1) % NREQ;
    end else begin
      m_resp = -1;
    end
    m_cyc = (m_cyc + 1) % SC;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (data_mode && i == 3) bif.req_data[64*i +: 64] = 64'(m_cyc);
      else                     bif.req_data[64*i +: 64] = {$urandom, $urandom};
    end
    if (rand_mode) begin
      bif.bus_hit_in  = ($urandom_range(0, 1) == 1) ? NREQ'($urandom) : '0;
      bif.bus_nack_in = ($urandom_range(0, 3) == 0) ? (NREQ'(1) << $urandom_range(0, NREQ-1)) : '0;
    end
    @(negedge clk);
    check_outputs();
    if (m_resp >= 0 && !m_nack && !rr_mode) bif.req_valid[m_resp] = 1'b0;
    if (rand_mode) begin
      for (int i = 0; i < NREQ; i++)
        if (!bif.req_valid[i] && $urandom_range(0, 3) == 0)
          raise(i, 3'($urandom), 5'($urandom), 26'($urandom));
    end
  endtask

  task automatic wait_slot(input int idx, input int cyc);
    int n;
    n = 0;
    while (!(m_gnt == idx && m_cyc == cyc) && n < 200) begin
      step();
      n++;
    end
    chk("wait_grant", 64'(bif.grant),     64'(NREQ'(1) << idx));
    chk("wait_cycle", 64'(bif.bus_cycle), 64'(cyc));
  endtask

  initial begin
    logic [NREQ-1:0] e_rr;
    int n;
    bif.req_valid = '0; bif.req_cmd = '0; bif.req_tag = '0; bif.req_addr = '0;
    bif.req_data = '0; bif.bus_hit_in = '0; bif.bus_nack_in = '0;
    m_cyc = 0; m_gnt = -1; m_ptr = 0; m_resp = -1; m_hit = 0; m_nack = 0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Single requester
    raise(0, CMD_BUSRD, 5'b10011, 26'h123456);
    wait_slot(0, 0);
    chk("single_valid", 64'(bif.bus_valid), 64'(1));
    chk("single_cmd",   64'(bif.bus_cmd),   64'(CMD_BUSRD));
    chk("single_tag",   64'(bif.bus_tag),   64'(5'b10011));
    chk("single_addr",  64'(bif.bus_addr),  64'(26'h123456));
    repeat (SC) step();
    chk("single_resp",  64'(bif.resp_valid), 64'(4'b0001));
    chk("single_nack",  64'(bif.resp_nack),  64'(0));

    // Nack retry
    raise(2, 3'b010, 5'b00101, 26'h2ABCDEF);
    wait_slot(2, SC - 1);
    bif.bus_nack_in = 4'b0010;
    step();
    bif.bus_nack_in = '0;
    chk("nack_resp",    64'(bif.resp_valid), 64'(4'b0100));
    chk("nack_flag",    64'(bif.resp_nack),  64'(1));
    chk("retry_idle",   64'(bif.grant),      64'(0));
    repeat (SC) step();
    chk("retry_regrant", 64'(bif.grant),     64'(4'b0100));

    // Hit only mid-slot is not sampled
    while (m_cyc != 3) step();
    bif.bus_hit_in = 4'b0001;
    step();
    bif.bus_hit_in = '0;
    while (m_cyc != SC - 1) step();
    step();
    chk("hit_mid_only", 64'(bif.resp_hit), 64'(0));

    // Hit at last cycle is merged
    raise(2, 3'b011, 5'b01110, 26'h0000ABC);
    wait_slot(2, SC - 1);
    bif.bus_hit_in = 4'b0110;
    step();
    bif.bus_hit_in = '0;
    chk("hit_merge", 64'(bif.resp_hit), 64'(1));

    // Data mux: grantee 3 presents the beat index
    data_mode = 1'b1;
    raise(3, 3'b100, 5'b11111, 26'h3FFFFFF);
    wait_slot(3, 0);
    for (int k = 0; k < SC; k++) begin
      chk("data_beat", bif.bus_data, 64'(k));
      step();
    end
    chk("data_idle", bif.bus_data, 64'(0));
    data_mode = 1'b0;

    // Round robin with all four continuously requesting
    rr_mode = 1'b1;
    for (int i = 0; i < NREQ; i++) raise(i, 3'($urandom), 5'($urandom), 26'($urandom));
    n = 0;
    while (!(m_cyc == 0 && m_gnt >= 0) && n < 50) begin step(); n++; end
    e_rr = NREQ'(1) << ((m_gnt < 0) ? 0 : m_gnt);
    chk("rr_first", 64'(bif.grant), 64'(e_rr));
    for (int s = 0; s < 5; s++) begin
      repeat (SC) step();
      e_rr = {e_rr[NREQ-2:0], e_rr[NREQ-1]};
      chk("rr_rotate", 64'(bif.grant), 64'(e_rr));
    end
    rr_mode = 1'b0;

    // Random traffic with random hit/nack
    rand_mode = 1'b1;
    repeat (60 * SC) step();
    rand_mode = 1'b0;
    bif.bus_hit_in = '0;
    bif.bus_nack_in = '0;

    // Reset mid-slot with requester 1 granted
    bif.req_valid = '0;
    raise(1, CMD_BUSRD, 5'b00001, 26'h0000111);
    wait_slot(1, 5);
    rst_n = 1'b0;
    #1;
    chk("rst_grant",      64'(bif.grant),      64'(0));
    chk("rst_cycle",      64'(bif.bus_cycle),  64'(0));
    chk("rst_bus_valid",  64'(bif.bus_valid),  64'(0));
    chk("rst_bus_cmd",    64'(bif.bus_cmd),    64'(0));
    chk("rst_bus_tag",    64'(bif.bus_tag),    64'(0));
    chk("rst_bus_addr",   64'(bif.bus_addr),   64'(0));
    chk("rst_bus_data",   bif.bus_data,        64'(0));
    chk("rst_resp_valid", 64'(bif.resp_valid), 64'(0));
    chk("rst_resp_hit",   64'(bif.resp_hit),   64'(0));
    chk("rst_resp_nack",  64'(bif.resp_nack),  64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    m_cyc = 0; m_gnt = -1; m_ptr = 0; m_resp = -1;
    check_outputs();
    repeat (3 * SC) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
